// File: rtl/phv_mcast_dispatch.sv
// rtl/phv_mcast_dispatch.sv - replicates each PHV to every queue FIFO in its destination bitmap
module phv_mcast_dispatch #(
    parameter int PHV_LEN   = 48*8+32*8+16*8+256,
    parameter int QMASK_OFF = 141,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst,

    input  logic [PHV_LEN-1:0]   phv_in,
    input  logic                 phv_in_valid,
    output logic                 phv_in_ready,

    output logic [PHV_LEN-1:0]   phv_out_0,
    output logic [PHV_LEN-1:0]   phv_out_1,
    output logic [PHV_LEN-1:0]   phv_out_2,
    output logic [PHV_LEN-1:0]   phv_out_3,
    output logic                 phv_out_valid_0,
    output logic                 phv_out_valid_1,
    output logic                 phv_out_valid_2,
    output logic                 phv_out_valid_3,
    input  logic                 phv_fifo_ready_0,
    input  logic                 phv_fifo_ready_1,
    input  logic                 phv_fifo_ready_2,
    input  logic                 phv_fifo_ready_3,

    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] repl_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Held PHV and the mask of copies still owed to each queue.
    logic [PHV_LEN-1:0]   phv_q,      phv_d;
    logic [3:0]           pending_q,  pending_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0] repl_cnt_q, repl_cnt_d;

    logic [3:0]           fifo_ready;
    logic [3:0]           deliver_mask;
    logic [3:0]           in_qmask;
    logic                 accept;
    logic [2:0]           deliver_cnt;
    logic [CNT_WIDTH:0]   repl_sum;

    assign fifo_ready   = {phv_fifo_ready_3, phv_fifo_ready_2,
                           phv_fifo_ready_1, phv_fifo_ready_0};
    assign deliver_mask = pending_q & fifo_ready;
    assign in_qmask     = phv_in[QMASK_OFF +: 4];

    // Ready whenever no owed copy is blocked, so the last-copy cycle can also take the next PHV.
    assign phv_in_ready = ((pending_q & ~fifo_ready) == 4'b0000);
    assign accept       = phv_in_valid && phv_in_ready;

    // Number of copies retiring this cycle.
    always_comb begin
        deliver_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            deliver_cnt = deliver_cnt + {2'b00, deliver_mask[i]};
        end
    end

    // One bit of headroom lets the replica counter detect overflow and clamp.
    assign repl_sum = {1'b0, repl_cnt_q} + {{(CNT_WIDTH-2){1'b0}}, deliver_cnt};

    // Next-state: a fresh accept replaces the (already empty) pending mask and held PHV.
    always_comb begin
        phv_d      = phv_q;
        pending_d  = pending_q & ~deliver_mask;
        drop_cnt_d = drop_cnt_q;
        repl_cnt_d = repl_sum[CNT_WIDTH] ? CNT_MAX : repl_sum[CNT_WIDTH-1:0];

        if (accept) begin
            phv_d     = phv_in;
            pending_d = in_qmask;
            if (in_qmask == 4'b0000 && drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any held PHV and clears statistics.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            phv_q      <= '0;
            pending_q  <= 4'b0000;
            drop_cnt_q <= '0;
            repl_cnt_q <= '0;
        end else begin
            phv_q      <= phv_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            repl_cnt_q <= repl_cnt_d;
        end
    end

    assign phv_out_0       = phv_q;
    assign phv_out_1       = phv_q;
    assign phv_out_2       = phv_q;
    assign phv_out_3       = phv_q;
    assign phv_out_valid_0 = pending_q[0];
    assign phv_out_valid_1 = pending_q[1];
    assign phv_out_valid_2 = pending_q[2];
    assign phv_out_valid_3 = pending_q[3];
    assign drop_cnt        = drop_cnt_q;
    assign repl_cnt        = repl_cnt_q;

endmodule

// File: tb/tb_phv_mcast_dispatch.sv
// tb/tb_phv_mcast_dispatch.sv - directed self-checking bench for phv_mcast_dispatch
module tb_phv_mcast_dispatch;

    localparam int PHV_LEN   = 48*8+32*8+16*8+256;
    localparam int QMASK_OFF = 141;

    logic               clk = 1'b0;
    logic               rst;
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic               r0, r1, r2, r3;

    logic               in_ready, s_in_ready;
    logic [PHV_LEN-1:0] o0, o1, o2, o3;
    logic [PHV_LEN-1:0] so0, so1, so2, so3;
    logic               v0, v1, v2, v3;
    logic               sv0, sv1, sv2, sv3;
    logic [31:0]        drop_cnt, repl_cnt;
    logic [3:0]         s_drop_cnt, s_repl_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phv_mcast_dispatch #(.PHV_LEN(PHV_LEN), .QMASK_OFF(QMASK_OFF), .CNT_WIDTH(32)) dut (
        .axis_clk(clk), .axis_rst(rst),
        .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(in_ready),
        .phv_out_0(o0), .phv_out_1(o1), .phv_out_2(o2), .phv_out_3(o3),
        .phv_out_valid_0(v0), .phv_out_valid_1(v1), .phv_out_valid_2(v2), .phv_out_valid_3(v3),
        .phv_fifo_ready_0(r0), .phv_fifo_ready_1(r1), .phv_fifo_ready_2(r2), .phv_fifo_ready_3(r3),
        .drop_cnt(drop_cnt), .repl_cnt(repl_cnt)
    );

    phv_mcast_dispatch #(.PHV_LEN(PHV_LEN), .QMASK_OFF(QMASK_OFF), .CNT_WIDTH(4)) dut_sat (
        .axis_clk(clk), .axis_rst(rst),
        .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(s_in_ready),
        .phv_out_0(so0), .phv_out_1(so1), .phv_out_2(so2), .phv_out_3(so3),
        .phv_out_valid_0(sv0), .phv_out_valid_1(sv1), .phv_out_valid_2(sv2), .phv_out_valid_3(sv3),
        .phv_fifo_ready_0(r0), .phv_fifo_ready_1(r1), .phv_fifo_ready_2(r2), .phv_fifo_ready_3(r3),
        .drop_cnt(s_drop_cnt), .repl_cnt(s_repl_cnt)
    );

    task automatic chk(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] mk(input logic [3:0] qmask, input logic [31:0] tag);
        logic [PHV_LEN-1:0] p;
        p = {(PHV_LEN/32){tag}};
        p[QMASK_OFF +: 4] = qmask;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        phv_in_valid = 1'b0;
        phv_in = '0;
        {r3, r2, r1, r0} = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Upstream must hold phv_in steady while stalled.
    logic               held = 1'b0;
    logic [PHV_LEN-1:0] last_phv;
    always @(posedge clk) begin
        if (held && phv_in_valid) begin
            checks++;
            assert (phv_in === last_phv) else begin
                errors++;
                $error("FAIL upstream_stable observed %0h expected %0h", phv_in, last_phv);
            end
        end
        held = phv_in_valid && !in_ready && !rst;
        last_phv = phv_in;
    end

    logic [PHV_LEN-1:0] pa, pb;

    initial begin
        rst = 1'b1;
        phv_in_valid = 1'b0;
        phv_in = '0;
        {r3, r2, r1, r0} = 4'b1111;

        // Reset state
        do_reset();
        chk("rst_valid", {v3, v2, v1, v0}, 4'b0000);
        chk("rst_out0", o0, '0);
        chk("rst_out3", o3, '0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_repl", repl_cnt, 0);

        // 1. Unicast back-to-back
        for (int k = 0; k < 5; k++) begin
            phv_in = mk(4'b0001, 32'h1000_0000 + k);
            phv_in_valid = 1'b1;
            #1;
            chk("uc_ready", in_ready, 1'b1);
            tick();
            chk("uc_v0", v0, 1'b1);
            chk("uc_out0", o0, mk(4'b0001, 32'h1000_0000 + k));
            chk("uc_v123", {v3, v2, v1}, 3'b000);
        end
        phv_in_valid = 1'b0;
        tick();
        chk("uc_v0_end", v0, 1'b0);
        chk("uc_repl", repl_cnt, 5);

        // 2. Multicast with queue 1 stalled for 3 cycles
        do_reset();
        pa = mk(4'b1011, 32'hB00B_0002);
        phv_in = pa;
        phv_in_valid = 1'b1;
        r1 = 1'b0;
        #1;
        chk("mc_ready_idle", in_ready, 1'b1);
        tick();
        phv_in_valid = 1'b0;
        phv_in = '0;
        chk("mc_valids_c1", {v3, v2, v1, v0}, 4'b1011);
        chk("mc_out1_c1", o1, pa);
        chk("mc_out3_c1", o3, pa);
        #1;
        chk("mc_ready_c1", in_ready, 1'b0);
        tick();
        chk("mc_valids_c2", {v3, v2, v1, v0}, 4'b0010);
        chk("mc_out1_c2", o1, pa);
        chk("mc_ready_c2", in_ready, 1'b0);
        tick();
        chk("mc_valids_c3", {v3, v2, v1, v0}, 4'b0010);
        chk("mc_out1_c3", o1, pa);
        chk("mc_ready_c3", in_ready, 1'b0);
        r1 = 1'b1;
        #1;
        chk("mc_ready_c4", in_ready, 1'b1);
        chk("mc_v1_c4", v1, 1'b1);
        chk("mc_out1_c4", o1, pa);
        tick();
        chk("mc_valids_done", {v3, v2, v1, v0}, 4'b0000);
        chk("mc_repl", repl_cnt, 3);

        // 3. Empty bitmap is dropped
        do_reset();
        phv_in = mk(4'b0000, 32'hDEAD_0003);
        phv_in_valid = 1'b1;
        #1;
        chk("drop_ready", in_ready, 1'b1);
        tick();
        phv_in_valid = 1'b0;
        chk("drop_valids", {v3, v2, v1, v0}, 4'b0000);
        chk("drop_cnt", drop_cnt, 1);
        chk("drop_repl", repl_cnt, 0);
        chk("drop_ready_after", in_ready, 1'b1);
        tick();
        chk("drop_valids2", {v3, v2, v1, v0}, 4'b0000);

        // 4. Overlap: B accepted in the cycle A retires
        do_reset();
        pa = mk(4'b0011, 32'hAAAA_0004);
        pb = mk(4'b0100, 32'hBBBB_0004);
        phv_in = pa;
        phv_in_valid = 1'b1;
        tick();
        phv_in = pb;
        #1;
        chk("ov_valids_a", {v3, v2, v1, v0}, 4'b0011);
        chk("ov_out0_a", o0, pa);
        chk("ov_ready_b", in_ready, 1'b1);
        tick();
        phv_in_valid = 1'b0;
        chk("ov_valids_b", {v3, v2, v1, v0}, 4'b0100);
        chk("ov_out2_b", o2, pb);
        tick();
        chk("ov_valids_end", {v3, v2, v1, v0}, 4'b0000);
        chk("ov_repl", repl_cnt, 3);

        // 5. Reset while a copy is blocked
        do_reset();
        pa = mk(4'b1000, 32'h5555_0005);
        r3 = 1'b0;
        phv_in = pa;
        phv_in_valid = 1'b1;
        tick();
        phv_in_valid = 1'b0;
        tick();
        chk("rm_v3_held", v3, 1'b1);
        chk("rm_ready_held", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_valids", {v3, v2, v1, v0}, 4'b0000);
        chk("rm_out3", o3, '0);
        chk("rm_ready", in_ready, 1'b1);
        chk("rm_drop", drop_cnt, 0);
        chk("rm_repl", repl_cnt, 0);
        r3 = 1'b1;
        pb = mk(4'b0001, 32'h6666_0005);
        phv_in = pb;
        phv_in_valid = 1'b1;
        tick();
        phv_in_valid = 1'b0;
        chk("rm_new_v0", v0, 1'b1);
        chk("rm_new_out0", o0, pb);
        tick();
        chk("rm_new_repl", repl_cnt, 1);

        // 6. Counter saturation on the 4-bit instance
        do_reset();
        for (int k = 0; k < 20; k++) begin
            phv_in = mk(4'b0000, 32'h0E00_0000 + k);
            phv_in_valid = 1'b1;
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            phv_in = mk(4'b1111, 32'h0F00_0000 + k);
            phv_in_valid = 1'b1;
            tick();
        end
        phv_in_valid = 1'b0;
        tick();
        chk("sat_drop", s_drop_cnt, 4'd15);
        chk("sat_repl", s_repl_cnt, 4'd15);
        chk("wide_drop", drop_cnt, 20);
        chk("wide_repl", repl_cnt, 24);
        chk("sat_valids", {sv3, sv2, sv1, sv0}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
